encapsulation: RTL and testbench
================================

// Module: encapsulation
// PURPOSE
//  Transmit-side framer for the ICAP controller serial link.
//  Buffers payload bytes in a FIFO and, on request, emits one frame to the
//  UART transmitter: flag, address, DLC, DLC data bytes, flag.
//  The frame format is exactly the one the receive-side decapsulation block
//  parses, so frames can be looped back byte-for-byte.
// PARAMETERS
//  flag_byte  8'h7E  start/end-of-frame marker; not escaped in payload
//  DEPTH      16     payload FIFO entries; power of two, 2..128
// PORTS
//  clk          in   1  system clock, all logic on rising edge
//  rstn         in   1  synchronous active-low reset
//  wr_data      in   8  payload byte to queue
//  wr_en        in   1  push wr_data into FIFO this cycle
//  fifo_full    out  1  FIFO holds DEPTH bytes
//  overflow     out  1  1-cycle pulse: wr_en while full, byte dropped
//  frame_addr   in   8  address field, sampled when a frame starts
//  send         in   1  1-cycle request to start a frame (IDLE only)
//  busy         out  1  high from frame start until final flag accepted
//  frame_done   out  1  1-cycle pulse on the cycle the final flag is accepted
//  data_tx      out  8  byte to UART transmitter
//  new_data_tx  out  1  valid; held with data_tx stable until tx_ready
//  tx_ready     in   1  UART accepts data_tx when new_data_tx && tx_ready
// BEHAVIOUR
//  Reset (rstn=0 at clk edge): state=IDLE, FIFO emptied, all outputs 0.
//   Applies mid-frame too: new_data_tx drops on that edge, frame abandoned.
//  FIFO: wr_ptr/rd_ptr with extra wrap bit; count = wr_ptr - rd_ptr (0..DEPTH).
//   Write and read in the same cycle are both honoured.
//   wr_en while full: byte dropped, overflow=1 for one cycle.
//   Writes are accepted in every state, including during a frame.
//  FSM: IDLE -> SOF -> ADDR -> DLC -> DATA -> EOF -> IDLE.
//  Leaving a state on transfer means on the cycle new_data_tx && tx_ready.
//  IDLE:
//   - send=1: latch addr_r=frame_addr and dlc_r=count (count before any
//     same-cycle write); busy=1; go to SOF.
//   - send while busy is ignored.
//  SOF: new_data_tx=1, data_tx=flag_byte. First byte is valid on the cycle
//   after send; latency is 1 clk. On transfer go to ADDR.
//  ADDR: data_tx=addr_r. On transfer go to DLC.
//  DLC: data_tx=dlc_r. On transfer go to DATA if dlc_r>0, else to EOF.
//  DATA: data_tx=FIFO head (combinational read). On each transfer pop one byte
//   and decrement remaining. When remaining hits 0, go to EOF.
//   Exactly dlc_r bytes are sent; bytes written after send stay queued.
//  EOF: data_tx=flag_byte. On transfer: frame_done=1, busy=0, go to IDLE.
//   The next send is honoured from the following cycle.
//  Back-to-back bytes at full rate when tx_ready stays 1: frame of N data
//   bytes occupies N+4 consecutive cycles.
//  data_tx is a don't-care while new_data_tx=0; drive 8'h00.
//  No byte stuffing: payload equal to flag_byte is sent raw. The receiver
//   relies on DLC, not on the flag, to find the frame end.
// CONFIGURATION
//  ENCAP_AUTOSEND_EN defined: in IDLE with count==DEPTH and no send, a frame
//   starts automatically with dlc_r=DEPTH and addr_r=frame_addr, exactly as
//   if send were pulsed. send on the same cycle is treated as one request.
//  Not defined: frames start only on send; a full FIFO just waits.
// TESTING
//  Write 8'hA1,8'hA2,8'hA3; send with frame_addr=8'h05, tx_ready=1 ->
//   stream 7E,05,03,A1,A2,A3,7E on 7 consecutive cycles, then frame_done.
//  send with empty FIFO, frame_addr=8'h10 -> 7E,10,00,7E; busy low afterwards.
//  tx_ready toggled randomly during a frame -> data_tx stable while stalled;
//   no byte lost or duplicated; loopback into decapsulation gives the same
//   address and data.
//  Fill 16 bytes, then wr_en once more -> overflow pulse, fifo_full=1;
//   frame carries DLC=8'h10.
//  Send 2 queued bytes; write 8'hCC mid-frame -> frame DLC=2, and 8'hCC is
//   sent in the next frame. Assert rstn=0 mid-DATA -> outputs 0 next cycle,
//   FIFO empty.
//  With ENCAP_AUTOSEND_EN defined, write 16 bytes and no send -> frame starts
//   automatically with DLC=8'h10.

Source files
------------

// File: rtl/encapsulation.sv
// Transmit-side framer for the ICAP serial link.
// Payload bytes are queued in a FIFO; on request one frame is emitted to the
// UART transmitter: flag, address, DLC, DLC data bytes, flag.
// Optional feature macro: ENCAP_AUTOSEND_EN -- when defined, a frame starts
// on its own as soon as the FIFO is full while idle.
//
// state  | meaning
// S_IDLE | waiting for send (or a full FIFO with autosend)
// S_SOF  | presenting the start flag
// S_ADDR | presenting the latched address
// S_DLC  | presenting the latched byte count
// S_DATA | presenting FIFO head, one pop per accepted byte
// S_EOF  | presenting the end flag
module encapsulation #(
    parameter logic [7:0] flag_byte = 8'h7E,
    parameter int         DEPTH     = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] wr_data,
    input  logic       wr_en,
    output logic       fifo_full,
    output logic       overflow,
    input  logic [7:0] frame_addr,
    input  logic       send,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] data_tx,
    output logic       new_data_tx,
    input  logic       tx_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOF,
        S_ADDR,
        S_DLC,
        S_DATA,
        S_EOF
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] count;
    logic [7:0]  addr_r;
    logic [7:0]  dlc_r;
    logic [7:0]  remaining;
    logic        push;
    logic        pop;
    logic        start;

    assign count     = wr_ptr - rd_ptr;
    assign fifo_full = (count == FULL_CNT);
    assign push      = wr_en && !fifo_full;
    assign overflow  = wr_en && fifo_full;
    assign pop       = (state == S_DATA) && tx_ready;

`ifdef ENCAP_AUTOSEND_EN
    // A full FIFO while idle behaves exactly like a send pulse.
    assign start = (state == S_IDLE) && (send || fifo_full);
`else
    assign start = (state == S_IDLE) && send;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // FIFO pointers; the extra wrap bit distinguishes full from empty
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (rstn && push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    // Frame header capture and data byte countdown
    always_ff @(posedge clk) begin
        if (!rstn) begin
            addr_r    <= 8'h00;
            dlc_r     <= 8'h00;
            remaining <= 8'h00;
        end else if (start) begin
            // count excludes any write landing this cycle, so it stays queued
            addr_r    <= frame_addr;
            dlc_r     <= 8'(count);
            remaining <= 8'(count);
        end else if (pop) begin
            remaining <= remaining - 8'd1;
        end
    end

    // Next state and byte presentation; a transfer is new_data_tx && tx_ready
    always_comb begin
        state_nxt   = state;
        new_data_tx = 1'b0;
        data_tx     = 8'h00;
        frame_done  = 1'b0;
        busy        = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_SOF;
            end
            S_SOF: begin
                new_data_tx = 1'b1;
                data_tx     = flag_byte;
                if (tx_ready) state_nxt = S_ADDR;
            end
            S_ADDR: begin
                new_data_tx = 1'b1;
                data_tx     = addr_r;
                if (tx_ready) state_nxt = S_DLC;
            end
            S_DLC: begin
                new_data_tx = 1'b1;
                data_tx     = dlc_r;
                if (tx_ready) state_nxt = (dlc_r != 8'h00) ? S_DATA : S_EOF;
            end
            S_DATA: begin
                new_data_tx = 1'b1;
                data_tx     = mem[rd_ptr[AW-1:0]];
                if (tx_ready && remaining == 8'd1) state_nxt = S_EOF;
            end
            S_EOF: begin
                new_data_tx = 1'b1;
                data_tx     = flag_byte;
                if (tx_ready) begin
                    frame_done = 1'b1;
                    state_nxt  = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_encapsulation.sv
// Scoreboard bench for the encapsulation framer. The driver keeps a queue
// model of the payload FIFO and, whenever a frame starts, pushes the whole
// expected byte stream; the monitor pops on every accepted byte.
module tb_encapsulation;

    localparam int DEPTH = 16;
`ifdef ENCAP_AUTOSEND_EN
    localparam bit AUTOSEND = 1'b1;
`else
    localparam bit AUTOSEND = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_en = 1'b0;
    logic       fifo_full;
    logic       overflow;
    logic [7:0] frame_addr = 8'h00;
    logic       send = 1'b0;
    logic       busy;
    logic       frame_done;
    logic [7:0] data_tx;
    logic       new_data_tx;
    logic       tx_ready = 1'b0;

    always #5 clk = ~clk;

    encapsulation #(.flag_byte(8'h7E), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .wr_data(wr_data), .wr_en(wr_en),
        .fifo_full(fifo_full), .overflow(overflow), .frame_addr(frame_addr),
        .send(send), .busy(busy), .frame_done(frame_done), .data_tx(data_tx),
        .new_data_tx(new_data_tx), .tx_ready(tx_ready)
    );

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] mfifo[$];
    logic [8:0] exp_q[$];
    int         cur_dlc = 0;
    bit         exp_ovf = 1'b0;
    bit         rand_ready = 1'b0;
    bit         mon_en = 1'b0;
    int         last_done_cyc = -1;
    bit         stalled = 1'b0;
    logic [7:0] held = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle of inputs and advance the reference model for it.
    task automatic drive(input bit wr, input logic [7:0] d, input bit snd, input logic [7:0] a);
        bit busy_m, full_m, start_m;
        int n;
        busy_m = (exp_q.size() != 0);
        // during a frame the DUT holds at most mfifo + cur_dlc bytes; never let it fill
        if (busy_m && wr && (mfifo.size() + cur_dlc >= DEPTH)) wr = 1'b0;
        full_m  = !busy_m && (mfifo.size() == DEPTH);
        start_m = !busy_m && (snd || (AUTOSEND && full_m));
        wr_en      = wr;
        wr_data    = d;
        send       = snd;
        frame_addr = a;
        tx_ready   = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (start_m) begin
            n = mfifo.size();
            cur_dlc = n;
            exp_q.push_back({1'b0, 8'h7E});
            exp_q.push_back({1'b0, a});
            exp_q.push_back({1'b0, n[7:0]});
            for (int i = 0; i < n; i++) exp_q.push_back({1'b0, mfifo.pop_front()});
            exp_q.push_back({1'b1, 8'h7E});
        end
        exp_ovf = wr && full_m;
        if (wr && !full_m) mfifo.push_back(d);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int wr_pct);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            drive($urandom_range(0, 99) < wr_pct, 8'($urandom),
                  (wr_pct > 0) && ($urandom_range(0, 19) == 0), 8'($urandom));
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d bytes still expected", exp_q.size());
            exp_q.delete();
        end
        chk("busy_after_frame", {8'h0, busy}, 9'h0);
    endtask

    task automatic do_reset();
        rstn    = 1'b0;
        wr_en   = 1'b0;
        send    = 1'b0;
        tx_ready = 1'b0;
        exp_ovf = 1'b0;
        exp_q.delete();
        mfifo.delete();
        cur_dlc = 0;
        @(posedge clk);
        #1;
        chk("rst_new_data_tx", {8'h0, new_data_tx}, 9'h0);
        chk("rst_data_tx", {1'b0, data_tx}, 9'h0);
        chk("rst_busy", {8'h0, busy}, 9'h0);
        chk("rst_fifo_full", {8'h0, fifo_full}, 9'h0);
        chk("rst_frame_done", {8'h0, frame_done}, 9'h0);
        chk("rst_overflow", {8'h0, overflow}, 9'h0);
        rstn = 1'b1;
    endtask

    // Monitor: compare every accepted byte against the scoreboard
    always @(negedge clk) begin : monitor
        logic [8:0] e;
        if (mon_en) begin
            chk("overflow", {8'h0, overflow}, {8'h0, exp_ovf});
            if (new_data_tx) begin
                if (stalled) chk("stall_stable", {1'b0, data_tx}, {1'b0, held});
                if (tx_ready) begin
                    stalled = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got %0h expected none", data_tx);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tx_byte", {1'b0, data_tx}, {1'b0, e[7:0]});
                        chk("frame_done", {8'h0, frame_done}, {8'h0, e[8]});
                        if (e[8]) last_done_cyc = cyc;
                    end
                end else begin
                    stalled = 1'b1;
                    held = data_tx;
                    chk("frame_done_stall", {8'h0, frame_done}, 9'h0);
                end
            end else begin
                stalled = 1'b0;
                chk("idle_data_tx", {1'b0, data_tx}, 9'h0);
                chk("idle_frame_done", {8'h0, frame_done}, 9'h0);
            end
        end
    end

    initial begin : stim
        int c0;
        int nw;
        do_reset();
        do_reset();
        mon_en = 1'b1;

        // three bytes at full rate: 7 consecutive transfers
        rand_ready = 1'b0;
        drive(1, 8'hA1, 0, 8'h00);
        drive(1, 8'hA2, 0, 8'h00);
        drive(1, 8'hA3, 0, 8'h00);
        c0 = cyc;
        drive(0, 8'h00, 1, 8'h05);
        chk("busy_after_send", {8'h0, busy}, 9'h1);
        wait_drain(0);
        chk("frame_len_cycles", 9'(last_done_cyc - c0), 9'd7);

        // empty frame
        drive(0, 8'h00, 1, 8'h10);
        wait_drain(0);

        // fill, overflow on the extra write, DLC = 16
        for (int i = 0; i < DEPTH; i++) drive(1, 8'(8'h40 + i), 0, 8'h00);
        chk("fifo_full", {8'h0, fifo_full}, 9'h1);
        drive(1, 8'hEE, 1, 8'h33);
        wait_drain(0);
        chk("fifo_empty_after", {8'h0, fifo_full}, 9'h0);

        // write during a frame stays queued for the next one
        drive(1, 8'h11, 0, 8'h00);
        drive(1, 8'h22, 0, 8'h00);
        drive(0, 8'h00, 1, 8'h44);
        drive(1, 8'hCC, 0, 8'h00);
        wait_drain(0);
        drive(0, 8'h00, 1, 8'h45);
        wait_drain(0);

        // reset in the middle of DATA abandons the frame and empties the FIFO
        for (int i = 0; i < 4; i++) drive(1, 8'(8'h90 + i), 0, 8'h00);
        drive(0, 8'h00, 1, 8'h66);
        for (int i = 0; i < 4; i++) drive(0, 8'h00, 0, 8'h00);
        do_reset();
        drive(0, 8'h00, 1, 8'h22);
        wait_drain(0);

`ifdef ENCAP_AUTOSEND_EN
        // full FIFO starts a frame with no send
        for (int i = 0; i < DEPTH; i++) drive(1, 8'(8'hB0 + i), 0, 8'h00);
        drive(0, 8'h00, 0, 8'h5A);
        chk("autosend_busy", {8'h0, busy}, 9'h1);
        wait_drain(0);
`endif

        // randomized frames with stalls, mid-frame writes and spurious sends
        rand_ready = 1'b1;
        for (int f = 0; f < 30; f++) begin
            nw = $urandom_range(0, 20);
            for (int i = 0; i < nw; i++) drive(1, 8'($urandom), 0, 8'($urandom));
            drive(0, 8'h00, 1, 8'($urandom));
            wait_drain(25);
        end

        rand_ready = 1'b0;
        drive(0, 8'h00, 0, 8'h00);
        drive(0, 8'h00, 0, 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
